// File: rtl/stoch_stream_gen.sv
// Stochastic number generator: compares a latched operand against the upstream PRNG
// word for a programmed number of cycles and counts the ones emitted. SSG_BIPOLAR_EN selects signed compare.
module stoch_stream_gen #(
    parameter int REG_BITS = 8,
    parameter int LEN_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [REG_BITS-1:0] value,
    input  logic [LEN_BITS-1:0] length,
    input  logic [REG_BITS-1:0] prng,
    output logic                busy,
    output logic                bit_valid,
    output logic                bit_out,
    output logic                done,
    output logic [LEN_BITS-1:0] ones_count
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [REG_BITS-1:0] value_q;
    logic [LEN_BITS-1:0] remaining;
    logic [LEN_BITS-1:0] acc;
    logic [LEN_BITS-1:0] acc_sum;
    logic                cmp_bit;
    logic                accept;
    logic                last;
    logic                busy_nxt;
    logic                valid_nxt;
    logic                done_nxt;

    // Unipolar encoding compares unsigned; bipolar treats both words as two's complement.
    function automatic logic stoch_cmp(input logic [REG_BITS-1:0] r,
                                       input logic [REG_BITS-1:0] v);
`ifdef SSG_BIPOLAR_EN
        logic signed [REG_BITS-1:0] rs;
        logic signed [REG_BITS-1:0] vs;
        rs = r;
        vs = v;
        return rs < vs;
`else
        return r < v;
`endif
    endfunction

    assign cmp_bit = stoch_cmp(prng, value_q);
    assign acc_sum = acc + {{(LEN_BITS-1){1'b0}}, cmp_bit};
    assign accept  = (state == IDLE) && start;
    assign last    = (remaining == {{(LEN_BITS-1){1'b0}}, 1'b1});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && (length != '0)) state_nxt = RUN;
            RUN:     if (last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A zero-length request completes in the accept cycle without ever entering RUN.
    always_comb begin
        busy_nxt  = (state_nxt == RUN);
        valid_nxt = (state == RUN);
        done_nxt  = (accept && (length == '0)) || ((state == RUN) && last);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy       <= 1'b0;
            bit_valid  <= 1'b0;
            bit_out    <= 1'b0;
            done       <= 1'b0;
            ones_count <= '0;
            value_q    <= '0;
            remaining  <= '0;
            acc        <= '0;
        end else begin
            busy      <= busy_nxt;
            bit_valid <= valid_nxt;
            done      <= done_nxt;
            if (accept) begin
                value_q   <= value;
                remaining <= length;
                acc       <= '0;
                if (length == '0) ones_count <= '0;
            end else if (state == RUN) begin
                bit_out   <= cmp_bit;
                acc       <= acc_sum;
                remaining <= remaining - 1'b1;
                if (last) ones_count <= acc_sum;
            end
        end
    end

endmodule

// File: tb/tb_stoch_stream_gen.sv
// Table-driven bench for stoch_stream_gen plus hand sequences for reset and back-to-back starts.
module tb_stoch_stream_gen;

`ifdef SSG_BIPOLAR_EN
    localparam bit BIP = 1'b1;
`else
    localparam bit BIP = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] value;
    logic [7:0] length;
    logic [7:0] prng;
    logic       busy;
    logic       bit_valid;
    logic       bit_out;
    logic       done;
    logic [7:0] ones_count;

    int checks = 0;
    int errors = 0;

    stoch_stream_gen #(.REG_BITS(8), .LEN_BITS(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .value(value), .length(length),
        .prng(prng), .busy(busy), .bit_valid(bit_valid), .bit_out(bit_out),
        .done(done), .ones_count(ones_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] value;
        logic [7:0] length;
        logic [7:0] prng;
        bit         sweep;
        bit         poke;
        bit         exp_bit;
        int         exp_ones;
        string      name;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_stream(input vec_t v);
        int nvalid = 0;
        int nones = 0;
        int ndone = 0;
        int nbusy = 0;
        int badbit = 0;
        int done_ok = 0;
        @(negedge clk);
        start = 1'b1; value = v.value; length = v.length; prng = v.prng;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < int'(v.length) + 4; c++) begin
            if (busy) nbusy++;
            if (bit_valid) begin
                nvalid++;
                if (bit_out) nones++;
                if (bit_out != v.exp_bit) badbit++;
            end
            if (done) begin
                ndone++;
                if (nvalid == int'(v.length) && (v.length == 0 || bit_valid)) done_ok = 1;
            end
            if (v.poke && c == 2) begin
                start = 1'b1; value = 8'hFF; length = 8'd3;
            end
            if (v.poke && c == 3) start = 1'b0;
            @(negedge clk);
            if (v.sweep) prng = prng + 8'd1;
        end
        chk({v.name, " valid_cycles"}, nvalid, int'(v.length));
        chk({v.name, " bit_value_errs"}, badbit, 0);
        chk({v.name, " ones_seen"}, nones, v.exp_ones);
        chk({v.name, " done_pulses"}, ndone, 1);
        chk({v.name, " done_aligned"}, done_ok, 1);
        chk({v.name, " busy_cycles"}, nbusy, int'(v.length));
        chk({v.name, " ones_count"}, int'(ones_count), v.exp_ones);
    endtask

    initial begin
        int n;
        vecs[0] = '{8'h80, 8'd4,   8'h7F, 1'b0, 1'b0, !BIP, BIP ? 0 : 4,   "unsigned_half"};
        vecs[1] = '{8'h00, 8'd10,  8'h00, 1'b1, 1'b0, 1'b0, 0,             "all_zero_sweep"};
        vecs[2] = '{8'h33, 8'd0,   8'h00, 1'b0, 1'b0, 1'b0, 0,             "zero_length"};
        vecs[3] = '{8'h40, 8'd6,   8'h50, 1'b0, 1'b1, 1'b0, 0,             "midstream_start"};
        vecs[4] = '{8'h80, 8'd2,   8'h00, 1'b0, 1'b0, !BIP, BIP ? 0 : 2,   "polarity"};
        vecs[5] = '{8'hFF, 8'd3,   8'hFE, 1'b0, 1'b0, 1'b1, 3,             "near_one"};
        vecs[6] = '{8'h10, 8'd5,   8'h10, 1'b0, 1'b0, 1'b0, 0,             "equal_words"};
        vecs[7] = '{8'hFF, 8'd255, 8'h00, 1'b0, 1'b0, !BIP, BIP ? 0 : 255, "max_length"};

        rst_n = 1'b0; start = 1'b0; value = '0; length = '0; prng = '0;
        #12;
        chk("reset busy", int'(busy), 0);
        chk("reset bit_valid", int'(bit_valid), 0);
        chk("reset done", int'(done), 0);
        chk("reset ones_count", int'(ones_count), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_stream(vecs[i]);

        // Asynchronous reset in the middle of a stream
        @(negedge clk);
        start = 1'b1; value = 8'hFF; length = 8'd8; prng = 8'h00;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_reset bit_valid", int'(bit_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async busy", int'(busy), 0);
        chk("async bit_valid", int'(bit_valid), 0);
        chk("async done", int'(done), 0);
        chk("async ones_count", int'(ones_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done || busy) n++;
        end
        chk("post_reset quiet", n, 0);
        run_stream('{8'hFF, 8'd3, 8'h00, 1'b0, 1'b0, !BIP, BIP ? 0 : 3, "after_reset"});

        // Start accepted in the cycle right after done
        @(negedge clk);
        start = 1'b1; value = 8'hFF; length = 8'd2; prng = 8'h00;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("b2b done_seen", int'(done), 1);
        chk("b2b first ones_count", int'(ones_count), BIP ? 0 : 2);
        start = 1'b1; value = 8'h80; length = 8'd1;
        @(negedge clk);
        start = 1'b0;
        chk("b2b busy", int'(busy), 1);
        @(negedge clk);
        chk("b2b bit_valid", int'(bit_valid), 1);
        chk("b2b done", int'(done), 1);
        chk("b2b bit_out", int'(bit_out), BIP ? 0 : 1);
        chk("b2b ones_count", int'(ones_count), BIP ? 0 : 1);
        @(negedge clk);
        chk("b2b idle bit_valid", int'(bit_valid), 0);
        chk("b2b idle done", int'(done), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
